// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA engine that copies BYTES bytes from page {src_hi, 8'h00} into OAM,
// one byte per CPB-clock M-cycle. While a transfer runs it takes the bus from the CPU.
module oam_dma_ctrl #(
    parameter int BYTES = 160,
    parameter int CPB   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_write_i,
    input  logic [7:0]  reg_d_wr_i,
    output logic [7:0]  reg_d_rd_o,
    output logic        busy_o,
    output logic        dma_active_o,
    output logic [15:0] dma_src_addr_o,
    input  logic [7:0]  dma_d_in_i,
    output logic [7:0]  oam_addr_o,
    output logic [7:0]  oam_d_wr_o,
    output logic        oam_write_o,
    output logic        done_o
);
    localparam int PW = $clog2(CPB);
    localparam logic [PW-1:0] PH_LAST = PW'(CPB - 1);
    localparam logic [7:0] IDX_LAST = 8'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0] idx_q, idx_d, src_q, src_d, reg_q, reg_d;
    logic done_q, done_d;
    logic last, xfer;

    assign last = phase_q == PH_LAST;
    assign xfer = state_q == XFER;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            idx_q   <= '0;
            src_q   <= '0;
            reg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            reg_q   <= reg_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = state_q == IDLE ? phase_q : phase_q + PW'(1);
        idx_d   = idx_q;
        src_d   = src_q;
        reg_d   = reg_q;
        done_d  = 1'b0;
        if (state_q == START && last) begin
            state_d = XFER;
            phase_d = '0;
            idx_d   = '0;
        end
        if (xfer && last) begin
            phase_d = '0;
            if (idx_q == IDX_LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + 8'd1;
            end
        end
        // A register write always wins, even over the final byte of a running transfer.
        if (reg_write_i) begin
            reg_d   = reg_d_wr_i;
            src_d   = reg_d_wr_i[7:5] == 3'b111 ? (reg_d_wr_i & 8'hDF) : reg_d_wr_i;
            state_d = START;
            phase_d = '0;
            idx_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign reg_d_rd_o     = reg_q;
    assign busy_o         = state_q != IDLE;
    assign dma_active_o   = xfer;
    assign dma_src_addr_o = {src_q, xfer ? idx_q : 8'h00};
    assign oam_write_o    = xfer && last;
    assign oam_addr_o     = xfer ? idx_q : 8'h00;
    assign oam_d_wr_o     = dma_d_in_i;
    assign done_o         = done_q;
endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

OAM DMA controller for the PPU: on a CPU write to the DMA register it copies 160 bytes from `{src_hi, 8'h00}` into OAM entries 0–159, one byte per M-cycle. It drives the `dma_src_addr`/`dma_d_in`/`dma_active` bus-takeover handshake into `ppu_m` and produces the OAM write port that `ppu_m` muxes ahead of the CPU path. It is the only writer of OAM during a transfer, and it holds the CPU off the bus while `dma_active` is high.

## Interface
Parameters:
- `BYTES`, 160, bytes per transfer; must be ≤ 256.
- `CPB`, 4, clocks per byte (one M-cycle); must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reg_write`  in  1  CPU write strobe to the DMA register (FF46).
- `reg_d_wr`  in  8  source high byte.
- `reg_d_rd`  out  8  last value written to `reg_d_wr`, unfolded.
- `busy`  out  1  high in START or XFER.
- `dma_active`  out  1  high in XFER only; bus taken from the CPU.
- `dma_src_addr`  out  16  bus read address.
- `dma_d_in`  in  8  bus read data; valid one clock after the address.
- `oam_addr`  out  8  OAM byte index.
- `oam_d_wr`  out  8  OAM write data.
- `oam_write`  out  1  OAM write strobe.
- `done`  out  1  one-clock pulse when a transfer completes.

## Operation
- State machine:
  - States: IDLE, START, XFER.
  - Registers: `src_hi[7:0]`, `idx[7:0]`, `phase[$clog2(CPB)-1:0]`, `reg_q[7:0]`.
- Reset values: state = IDLE; `src_hi`, `idx`, `phase`, `reg_q` = 0.
  - Resulting outputs: `busy`, `dma_active`, `oam_write`, `done` = 0; `reg_d_rd` = 0; `dma_src_addr` = 0.
- Register write (`reg_write`=1, any state):
  - `reg_q` ← `reg_d_wr`.
  - `src_hi` ← `reg_d_wr`, but if `reg_d_wr` ≥ 8'hE0 then `src_hi` ← `reg_d_wr & 8'hDF`. This folds E0–FF onto C0–DF.
  - State ← START; `phase` ← 0; `idx` ← 0.
  - A write during START or XFER restarts the transfer from byte 0. `dma_active` drops to 0 for the START period.
- START: `phase` counts 0..CPB-1. At `phase` = CPB-1 → XFER, with `phase` ← 0 and `idx` ← 0.
- XFER:
  - `dma_src_addr` = `{src_hi, idx}`, held for the whole M-cycle.
  - `phase` counts 0..CPB-1.
  - `oam_write` = 1 combinationally when `phase` = CPB-1, with `oam_addr` = `idx` and `oam_d_wr` = `dma_d_in`.
  - At `phase` = CPB-1:
    - If `idx` = BYTES-1: state → IDLE and `done` ← 1 (registered, one clock).
    - Otherwise: `idx` ← `idx`+1 and `phase` ← 0.
- IDLE: `dma_src_addr` = `{src_hi, 8'h00}`; `oam_addr` = 0; `oam_write` = 0.
- `reg_write` wins over the completion step in the same clock: the new transfer starts and `done` is not pulsed.
- Arithmetic: `idx` is 8-bit with no wrap reachable. `dma_src_addr` low byte is `idx` directly, so the source never crosses a 256-byte page.
- Asynchronous reset mid-transfer aborts immediately: no further `oam_write`, and `done` is not pulsed.

## Timing
- Edge E0 samples `reg_write`. START covers the CPB cycles after E0.
- XFER begins after edge E0+CPB. `dma_active` is high for exactly BYTES·CPB cycles (640 at defaults).
- Write k (k = 0..BYTES-1) is asserted in the cycle after edge E0+CPB+k·CPB+(CPB-1).
- Source address for byte k is stable from the start of its M-cycle. `dma_d_in` is sampled CPB-1 clocks after the address first appears, which satisfies the 1-clock read latency.
- `done` is high for the one cycle after the edge on which state returns to IDLE. `dma_active` is 0 in that same cycle.
- Exactly BYTES `oam_write` pulses per uninterrupted transfer; never two in consecutive clocks.

## Test plan
- Basic copy: model memory so `mem[A]` = A[7:0]^8'h5A. Write 8'hC0. Expect:
  - 160 OAM writes, `oam_addr` 0..159, `oam_d_wr` = i^8'h5A.
  - `dma_src_addr` sequence C000..C09F.
  - First write 2·CPB-1 cycles after the `reg_write` edge; `done` after 160·CPB+CPB cycles.
- Fold: write 8'hE5. Expect `dma_src_addr` C500..C59F and `reg_d_rd` = 8'hE5. Write 8'hFF → source DF00.
- Restart: write 8'hC0, then write 8'hD0 after 50 OAM writes. Expect:
  - `dma_active` low for CPB cycles.
  - Writes resume at `oam_addr` 0 from D000; 160 further writes; a single `done`.
- Collision: assert `reg_write` on the last-byte completion clock. Expect no `done`, START entered, and a fresh 160-byte transfer.
- Reset mid-transfer: pull `rst_n` low after 80 writes. Expect:
  - All outputs immediately at reset values; no `done`.
  - After release, IDLE with no `oam_write` until the next `reg_write`.
- Parameter check: BYTES=8, CPB=2, write 8'h80. Expect 8 writes from 8000..8007, each 2 cycles apart, with `dma_active` high for 16 cycles.
